butterfly_pipe: RTL and testbench
=================================

BUTTERFLY_PIPE -- requirements
Module: butterfly_pipe

Interface
REQ-001 Parameters: DW, default 16, signed data width per real/imag component.
REQ-002 Parameters: TW, default 16, signed twiddle width, Q1.(TW-1) format.
REQ-003 Parameters: N, default 8, FFT size, power of two >= 4; KW = $clog2(N/2).
REQ-004 Parameters: SCALE, default 1; 1 = outputs arithmetic-shifted right by 1, 0 = unscaled with saturation.
REQ-005 Ports: clk, input, 1, single clock, rising edge.
REQ-006 Ports: rst_n, input, 1, asynchronous active-low reset.
REQ-007 Ports: in_valid, input, 1, input sample pair valid.
REQ-008 Ports: in_ready, output, 1, block accepts input this cycle.
REQ-009 Ports: k, input, KW, twiddle index.
REQ-010 Ports: inverse, input, 1, selects the conjugate twiddle (IFFT).
REQ-011 Ports: a_re, a_im, b_re, b_im, input, DW each, signed operands.
REQ-012 Ports: out_valid, input-side pair: out_valid output 1 and out_ready input 1, standard valid/ready.
REQ-013 Ports: oa_re, oa_im, ob_re, ob_im, output, DW each, signed results.
REQ-014 Ports: ovf, output, 1, saturation occurred on the current output sample; qualified by out_valid.

Function
REQ-015 Transfer occurs when valid and ready are both high; k and inverse are sampled with the operands.
REQ-016 Output: A' = A + W*B and B' = A - W*B, where W = cos(2*pi*k/N) - j*sin(2*pi*k/N); when inverse=1 the imaginary part of W is negated.
REQ-017 Three register stages.
  - S1 registers operands and the twiddle lookup.
  - S2 performs the complex multiply.
  - S3 performs the add/subtract, scaling and saturation.
  - Latency is 3 cycles from accept to out_valid with no stall.
REQ-018 Throughput is one sample per cycle while out_ready=1.
REQ-019 Each stage loads when its own valid is 0 or the next stage loads; S3 loads when out_ready=1 or out_valid=0.
REQ-020 in_ready is S1's load condition; combinational paths from out_ready to in_ready are permitted. Bubbles collapse.
REQ-021 The twiddle ROM holds round(x*2^(TW-1)), clipped to [-2^(TW-1), 2^(TW-1)-1]; cos(0) is therefore 2^(TW-1)-1.
REQ-022 Multiply: full-precision products; add 2^(TW-2); arithmetic-shift right by TW-1; hold the result at DW+1 bits.
REQ-023 Add/subtract is performed at DW+2 bits.
  - SCALE=1: arithmetic shift right by 1 (truncation), then saturate to DW.
  - SCALE=0: saturate to DW directly.
REQ-024 Saturation clamps to 2^(DW-1)-1 or -2^(DW-1); ovf is the OR of the clamp events of the four components of that sample.
REQ-025 Outputs and ovf are held stable while out_valid=1 and out_ready=0.
REQ-026 No sample is dropped, duplicated or reordered under any out_ready pattern.

Reset
REQ-027 While rst_n=0: all stage valid flags, out_valid and ovf are 0; all data registers and outputs are 0; in_ready is 1 after reset.
REQ-028 Reset mid-operation discards every in-flight sample; none appears after rst_n rises.
REQ-029 Reset assertion is asynchronous; deassertion is synchronised externally.

Structure
REQ-030 The shared package fft_pkg holds the twiddle function and constants, and the saturate and round helper functions.
REQ-031 One sub-module, twiddle_rom (parameters N, TW; input k, inverse; output w_re, w_im), is combinational and generated from the package function.
REQ-032 The butterfly arithmetic and pipeline control live in butterfly_pipe; there is no other sub-module.

Verification (N=8, DW=16, TW=16)
REQ-033 SCALE=0, k=0, a=(1000,0), b=(200,0) -> oa=(1200,0), ob=(800,0), ovf=0, out_valid exactly 3 cycles after accept.
REQ-034 SCALE=0, k=2 (W=-j), a=(0,0), b=(100,0) -> oa=(0,-100), ob=(0,100); same with inverse=1 -> oa=(0,100), ob=(0,-100).
REQ-035 SCALE=0, k=0, a=(30000,0), b=(30000,0) -> oa=(32767,0), ob=(1,0), ovf=1; same with SCALE=1 -> oa=(29999,0), ob=(0,0), ovf=0.
REQ-036 Stream 8 random samples with out_ready low on cycles 4-7 -> in_ready falls once 3 samples are in flight, and outputs match the golden model in order with no loss.
REQ-037 Pull rst_n low with 2 samples in flight -> out_valid=0 and outputs=0 immediately; no output for those samples after release; the next accepted sample emerges 3 cycles later.
REQ-038 Random stimulus with random out_ready against a reference model, all k, both inverse values and both SCALE values -> bit-exact match and correct ovf.

Source files
------------

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT constants, twiddle generation and fixed-point helpers
package fft_pkg;

   localparam real PI = 3.14159265358979323846;

   // cos(x) by Taylor series; valid for x in [0, pi/2]
   function automatic real cos_poly(input real x);
      real term;
      real sum;
      term = 1.0;
      sum  = 1.0;
      for (int i = 1; i <= 12; i++) begin
         term = -term * x * x / real'((2 * i - 1) * (2 * i));
         sum  = sum + term;
      end
      return sum;
   endfunction

   // Angle of twiddle index k for an n-point transform
   function automatic real tw_angle(input int k, input int n);
      return 2.0 * PI * real'(k) / real'(n);
   endfunction

   // cos over [0, pi] folded onto the series range
   function automatic real tw_cos_real(input real th);
      if (th <= PI / 2.0) return cos_poly(th);
      else return -cos_poly(PI - th);
   endfunction

   // sin over [0, pi], always >= 0
   function automatic real tw_sin_real(input real th);
      real d;
      d = PI / 2.0 - th;
      if (d < 0.0) d = -d;
      return cos_poly(d);
   endfunction

   // round(x * 2^(tw-1)) clipped to the signed tw-bit range
   function automatic int tw_quant(input real x, input int tw);
      real s;
      int  r;
      int  mx;
      int  mn;
      s  = x * real'(longint'(1) << (tw - 1));
      if (s >= 0.0) r = $rtoi(s + 0.5);
      else r = -$rtoi(-s + 0.5);
      mx = (1 << (tw - 1)) - 1;
      mn = -mx - 1;
      if (r > mx) r = mx;
      if (r < mn) r = mn;
      return r;
   endfunction

   function automatic int tw_cos(input int k, input int n, input int tw);
      return tw_quant(tw_cos_real(tw_angle(k, n)), tw);
   endfunction

   function automatic int tw_sin(input int k, input int n, input int tw);
      return tw_quant(tw_sin_real(tw_angle(k, n)), tw);
   endfunction

   // Round-half-up then arithmetic shift right by sh
   function automatic longint round_shift(input longint x, input int sh);
      return (x + (longint'(1) << (sh - 1))) >>> sh;
   endfunction

   // Clamp to the signed w-bit range
   function automatic longint sat_val(input longint x, input int w);
      longint mx;
      longint mn;
      mx = (longint'(1) << (w - 1)) - 1;
      mn = -mx - 1;
      if (x > mx) return mx;
      else if (x < mn) return mn;
      else return x;
   endfunction

   // True when sat_val would clamp
   function automatic logic sat_hit(input longint x, input int w);
      longint mx;
      longint mn;
      mx = (longint'(1) << (w - 1)) - 1;
      mn = -mx - 1;
      return (x > mx) || (x < mn);
   endfunction

endpackage

// File: rtl/twiddle_rom.sv
// rtl/twiddle_rom.sv - combinational twiddle lookup, conjugated for inverse transforms
module twiddle_rom
   import fft_pkg::*;
#(
   parameter int N  = 8,
   parameter int TW = 16
) (
   input  logic [$clog2(N/2)-1:0] k,
   input  logic                   inverse,
   output logic signed [TW-1:0]   w_re,
   output logic signed [TW-1:0]   w_im
);

   logic signed [TW-1:0] cos_tab [N/2];
   logic signed [TW-1:0] sin_tab [N/2];

   for (genvar i = 0; i < N / 2; i++) begin : g_tab
      assign cos_tab[i] = TW'(tw_cos(i, N, TW));
      assign sin_tab[i] = TW'(tw_sin(i, N, TW));
   end

   // Forward twiddle is cos - j*sin; inverse flips the imaginary sign
   always_comb begin
      w_re = cos_tab[k];
      w_im = inverse ? sin_tab[k] : -sin_tab[k];
   end

endmodule

// File: rtl/butterfly_pipe.sv
// rtl/butterfly_pipe.sv - three-stage radix-2 butterfly with valid/ready flow control
module butterfly_pipe
   import fft_pkg::*;
#(
   parameter int DW    = 16,
   parameter int TW    = 16,
   parameter int N     = 8,
   parameter int SCALE = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [$clog2(N/2)-1:0] k,
   input  logic                   inverse,
   input  logic signed [DW-1:0]   a_re,
   input  logic signed [DW-1:0]   a_im,
   input  logic signed [DW-1:0]   b_re,
   input  logic signed [DW-1:0]   b_im,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic signed [DW-1:0]   oa_re,
   output logic signed [DW-1:0]   oa_im,
   output logic signed [DW-1:0]   ob_re,
   output logic signed [DW-1:0]   ob_im,
   output logic                   ovf
);

   logic signed [TW-1:0] rom_re;
   logic signed [TW-1:0] rom_im;

   logic                 s1_valid;
   logic signed [DW-1:0] s1_a_re, s1_a_im, s1_b_re, s1_b_im;
   logic signed [TW-1:0] s1_w_re, s1_w_im;

   logic                 s2_valid;
   logic signed [DW-1:0] s2_a_re, s2_a_im;
   logic signed [DW:0]   s2_wb_re, s2_wb_im;

   logic ld1, ld2, ld3;

   longint prod_re, prod_im;
   longint sum_ar, sum_ai, sum_br, sum_bi;

   twiddle_rom #(.N(N), .TW(TW)) u_rom (
      .k       (k),
      .inverse (inverse),
      .w_re    (rom_re),
      .w_im    (rom_im)
   );

   // A stage loads when empty or when its contents move on; bubbles collapse
   assign ld3      = out_ready | ~out_valid;
   assign ld2      = ~s2_valid | ld3;
   assign ld1      = ~s1_valid | ld2;
   assign in_ready = ld1;

   // S1: capture operands and the looked-up twiddle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_a_re  <= '0;
         s1_a_im  <= '0;
         s1_b_re  <= '0;
         s1_b_im  <= '0;
         s1_w_re  <= '0;
         s1_w_im  <= '0;
      end else if (ld1) begin
         s1_valid <= in_valid;
         s1_a_re  <= a_re;
         s1_a_im  <= a_im;
         s1_b_re  <= b_re;
         s1_b_im  <= b_im;
         s1_w_re  <= rom_re;
         s1_w_im  <= rom_im;
      end
   end

   // Full-precision complex product W*B, rounded back to DW+1 bits below
   always_comb begin
      prod_re = longint'(s1_w_re) * longint'(s1_b_re) - longint'(s1_w_im) * longint'(s1_b_im);
      prod_im = longint'(s1_w_re) * longint'(s1_b_im) + longint'(s1_w_im) * longint'(s1_b_re);
   end

   // S2: register A and the rounded product
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_a_re  <= '0;
         s2_a_im  <= '0;
         s2_wb_re <= '0;
         s2_wb_im <= '0;
      end else if (ld2) begin
         s2_valid <= s1_valid;
         s2_a_re  <= s1_a_re;
         s2_a_im  <= s1_a_im;
         s2_wb_re <= (DW+1)'(round_shift(prod_re, TW - 1));
         s2_wb_im <= (DW+1)'(round_shift(prod_im, TW - 1));
      end
   end

   // Sum and difference, optionally halved before saturation
   always_comb begin
      sum_ar = longint'(s2_a_re) + longint'(s2_wb_re);
      sum_ai = longint'(s2_a_im) + longint'(s2_wb_im);
      sum_br = longint'(s2_a_re) - longint'(s2_wb_re);
      sum_bi = longint'(s2_a_im) - longint'(s2_wb_im);
      if (SCALE != 0) begin
         sum_ar = sum_ar >>> 1;
         sum_ai = sum_ai >>> 1;
         sum_br = sum_br >>> 1;
         sum_bi = sum_bi >>> 1;
      end
   end

   // S3: saturate into the output register, held while the sink stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         oa_re     <= '0;
         oa_im     <= '0;
         ob_re     <= '0;
         ob_im     <= '0;
         ovf       <= 1'b0;
      end else if (ld3) begin
         out_valid <= s2_valid;
         oa_re     <= DW'(sat_val(sum_ar, DW));
         oa_im     <= DW'(sat_val(sum_ai, DW));
         ob_re     <= DW'(sat_val(sum_br, DW));
         ob_im     <= DW'(sat_val(sum_bi, DW));
         ovf       <= s2_valid & (sat_hit(sum_ar, DW) | sat_hit(sum_ai, DW) |
                                  sat_hit(sum_br, DW) | sat_hit(sum_bi, DW));
      end
   end

endmodule

// File: tb/tb_butterfly_pipe.sv
// tb/tb_butterfly_pipe.sv - scoreboard bench for butterfly_pipe, SCALE=0 and SCALE=1 side by side
module tb_butterfly_pipe;

   localparam int DW = 16;
   localparam int TW = 16;
   localparam int N  = 8;
   localparam int KW = $clog2(N / 2);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic [KW-1:0] k = '0;
   logic inverse = 1'b0;
   logic signed [DW-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
   logic out_ready = 1'b1;

   logic in_ready0, out_valid0, ovf0;
   logic signed [DW-1:0] oa_re0, oa_im0, ob_re0, ob_im0;
   logic in_ready1, out_valid1, ovf1;
   logic signed [DW-1:0] oa_re1, oa_im1, ob_re1, ob_im1;

   always #5 clk = ~clk;

   butterfly_pipe #(.DW(DW), .TW(TW), .N(N), .SCALE(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
      .k(k), .inverse(inverse), .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
      .out_valid(out_valid0), .out_ready(out_ready),
      .oa_re(oa_re0), .oa_im(oa_im0), .ob_re(ob_re0), .ob_im(ob_im0), .ovf(ovf0)
   );

   butterfly_pipe #(.DW(DW), .TW(TW), .N(N), .SCALE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .k(k), .inverse(inverse), .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
      .out_valid(out_valid1), .out_ready(out_ready),
      .oa_re(oa_re1), .oa_im(oa_im1), .ob_re(ob_re1), .ob_im(ob_im1), .ovf(ovf1)
   );

   typedef struct {
      longint oa_re;
      longint oa_im;
      longint ob_re;
      longint ob_im;
      bit     ovf;
      int     cyc;
      bit     lat;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   ready_mode = 0;
   int   win_lo = 0;
   int   win_hi = -1;
   bit   took = 1'b0;
   bit   saw_stall = 1'b0;
   bit   use_ovr = 1'b0;
   exp_t ovr0, ovr1;

   task automatic check(input string tag, input longint got, input longint exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic longint q_tw(input real x);
      real    s;
      longint r;
      s = x * 32768.0;
      if (s < 0.0) r = -longint'($rtoi(-s + 0.5));
      else r = longint'($rtoi(s + 0.5));
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      return r;
   endfunction

   function automatic longint wrap17(input longint x);
      logic signed [16:0] t;
      t = 17'(x);
      return longint'(t);
   endfunction

   function automatic exp_t model(input int kk, input bit inv, input bit scale,
                                  input longint ar, input longint ai,
                                  input longint br, input longint bi);
      exp_t   e;
      real    th;
      longint wr, wi, pr, pim;
      longint s[4];
      th  = 2.0 * 3.14159265358979323846 * real'(kk) / real'(N);
      wr  = q_tw($cos(th));
      wi  = -q_tw($sin(th));
      if (inv) wi = -wi;
      pr  = wrap17((wr * br - wi * bi + 16384) >>> 15);
      pim = wrap17((wr * bi + wi * br + 16384) >>> 15);
      s[0] = ar + pr;
      s[1] = ai + pim;
      s[2] = ar - pr;
      s[3] = ai - pim;
      e.ovf = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (scale) s[i] = s[i] >>> 1;
         if (s[i] > 32767) begin s[i] = 32767; e.ovf = 1'b1; end
         if (s[i] < -32768) begin s[i] = -32768; e.ovf = 1'b1; end
      end
      e.oa_re = s[0];
      e.oa_im = s[1];
      e.ob_re = s[2];
      e.ob_im = s[3];
      e.cyc = 0;
      e.lat = 1'b0;
      return e;
   endfunction

   task automatic cmp_out(input string tag, input exp_t e, input longint ore, input longint oim,
                          input longint bre, input longint bim, input bit ov);
      check({tag, ".oa_re"}, ore, e.oa_re);
      check({tag, ".oa_im"}, oim, e.oa_im);
      check({tag, ".ob_re"}, bre, e.ob_re);
      check({tag, ".ob_im"}, bim, e.ob_im);
      check({tag, ".ovf"}, longint'(ov), longint'(e.ovf));
      if (e.lat) check({tag, ".latency"}, longint'(cyc - e.cyc), 3);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Sink-side ready pattern
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         1:       out_ready = 1'($urandom_range(0, 1));
         2:       out_ready = !(cyc >= win_lo && cyc <= win_hi);
         default: out_ready = 1'b1;
      endcase
   end

   // Monitor: decisions made at negedge take effect on the following posedge
   always @(negedge clk) begin
      exp_t e;
      took = 1'b0;
      if (rst_n) begin
         check("dut0.in_ready", longint'(in_ready0), longint'(q0.size() < 3 || out_ready));
         check("dut1.in_ready", longint'(in_ready1), longint'(q1.size() < 3 || out_ready));
         if (!in_ready0) saw_stall = 1'b1;
         if (out_valid0 && out_ready) begin
            if (q0.size() == 0) check("dut0.spurious", 1, 0);
            else begin
               e = q0.pop_front();
               cmp_out("dut0", e, oa_re0, oa_im0, ob_re0, ob_im0, ovf0);
            end
         end
         if (out_valid1 && out_ready) begin
            if (q1.size() == 0) check("dut1.spurious", 1, 0);
            else begin
               e = q1.pop_front();
               cmp_out("dut1", e, oa_re1, oa_im1, ob_re1, ob_im1, ovf1);
            end
         end
         if (in_valid && in_ready0) begin
            took = 1'b1;
            e = use_ovr ? ovr0 : model(int'(k), inverse, 1'b0, a_re, a_im, b_re, b_im);
            e.cyc = cyc;
            e.lat = (ready_mode == 0);
            q0.push_back(e);
            e = use_ovr ? ovr1 : model(int'(k), inverse, 1'b1, a_re, a_im, b_re, b_im);
            e.cyc = cyc;
            e.lat = (ready_mode == 0);
            q1.push_back(e);
         end
      end
   end

   task automatic send(input int kk, input bit inv, input longint ar, input longint ai,
                       input longint br, input longint bi);
      int n;
      n = 0;
      in_valid = 1'b1;
      k = KW'(kk);
      inverse = inv;
      a_re = DW'(ar);
      a_im = DW'(ai);
      b_re = DW'(br);
      b_im = DW'(bi);
      do begin
         @(posedge clk);
         n++;
      end while (!took && n < 200);
      if (!took) check("send_timeout", 0, 1);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_exp(input int kk, input bit inv, input longint ar, input longint ai,
                           input longint br, input longint bi,
                           input longint e0[5], input longint e1[5]);
      ovr0.oa_re = e0[0]; ovr0.oa_im = e0[1]; ovr0.ob_re = e0[2]; ovr0.ob_im = e0[3];
      ovr0.ovf = e0[4] != 0;
      ovr1.oa_re = e1[0]; ovr1.oa_im = e1[1]; ovr1.ob_re = e1[2]; ovr1.ob_im = e1[3];
      ovr1.ovf = e1[4] != 0;
      use_ovr = 1'b1;
      send(kk, inv, ar, ai, br, bi);
      use_ovr = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 1000) begin
         @(posedge clk);
         n++;
      end
      check("drain.q0", q0.size(), 0);
      check("drain.q1", q1.size(), 0);
      #1;
   endtask

   function automatic longint rnd_val();
      case ($urandom_range(0, 7))
         0:       return 32767;
         1:       return -32768;
         default: return longint'($signed(16'($urandom)));
      endcase
   endfunction

   initial begin
      longint e0[5];
      longint e1[5];
      int     start;

      repeat (3) @(posedge clk);
      #1;
      check("rst.out_valid", out_valid0, 0);
      check("rst.in_ready", in_ready0, 1);
      check("rst.oa_re", oa_re0, 0);
      check("rst.ob_im", ob_im0, 0);
      check("rst.ovf", ovf0, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      e0 = '{1200, 0, 800, 0, 0};       e1 = '{600, 0, 400, 0, 0};
      send_exp(0, 0, 1000, 0, 200, 0, e0, e1);
      e0 = '{0, -100, 0, 100, 0};       e1 = '{0, -50, 0, 50, 0};
      send_exp(2, 0, 0, 0, 100, 0, e0, e1);
      e0 = '{0, 100, 0, -100, 0};       e1 = '{0, 50, 0, -50, 0};
      send_exp(2, 1, 0, 0, 100, 0, e0, e1);
      e0 = '{32767, 0, 1, 0, 1};        e1 = '{29999, 0, 0, 0, 0};
      send_exp(0, 0, 30000, 0, 30000, 0, e0, e1);
      drain();

      start = cyc;
      win_lo = start + 4;
      win_hi = start + 7;
      saw_stall = 1'b0;
      ready_mode = 2;
      for (int i = 0; i < 8; i++)
         send($urandom_range(0, N / 2 - 1), 1'($urandom_range(0, 1)),
              rnd_val(), rnd_val(), rnd_val(), rnd_val());
      drain();
      check("stream.stall_seen", saw_stall, 1);
      ready_mode = 0;
      @(posedge clk);
      #1;

      send(1, 0, 500, -300, 1200, 700);
      send(3, 1, -800, 50, 90, -4000);
      rst_n = 1'b0;
      #1;
      check("midrst.out_valid0", out_valid0, 0);
      check("midrst.out_valid1", out_valid1, 0);
      check("midrst.oa_re0", oa_re0, 0);
      check("midrst.ob_re0", ob_re0, 0);
      check("midrst.in_ready0", in_ready0, 1);
      q0.delete();
      q1.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("midrst.quiet", out_valid0 | out_valid1, 0);
      send(1, 1, 1234, -567, -2222, 3333);
      drain();

      ready_mode = 1;
      for (int i = 0; i < 300; i++) begin
         send($urandom_range(0, N / 2 - 1), 1'($urandom_range(0, 1)),
              rnd_val(), rnd_val(), rnd_val(), rnd_val());
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
         end
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
